// File: rtl/o_ddr_tx_arbiter_if.sv
// o_ddr_tx_arbiter_if: requester valid/ready bundle plus the O_DDR lane outputs
//   req_valid_i/req_data0_i/req_data1_i : requester side, driven by master
//   req_ready_o                         : per-requester accept strobe
//   ddr_data_o/ddr_en_o                 : pair and enable towards O_DDR
//   busy_o/grant_id_o                   : status
interface o_ddr_tx_arbiter_if #(parameter int DATA_W = 8);
    logic [1:0]        req_valid_i;
    logic [DATA_W-1:0] req_data0_i;
    logic [DATA_W-1:0] req_data1_i;
    logic [1:0]        req_ready_o;
    logic [1:0]        ddr_data_o;
    logic              ddr_en_o;
    logic              busy_o;
    logic              grant_id_o;
    modport master (
        output req_valid_i, req_data0_i, req_data1_i,
        input  req_ready_o, ddr_data_o, ddr_en_o, busy_o, grant_id_o
    );
    modport slave (
        input  req_valid_i, req_data0_i, req_data1_i,
        output req_ready_o, ddr_data_o, ddr_en_o, busy_o, grant_id_o
    );
endinterface

// File: rtl/o_ddr_tx_arbiter.sv
// o_ddr_tx_arbiter: round-robin arbiter serializing two requesters' words onto one O_DDR lane
//   clk_i    : clock, all state on posedge
//   reset_n  : asynchronous active-low reset
//   enable_i : run enable, low freezes the block (ddr_en_o and req_ready_o forced low)
//   bus      : o_ddr_tx_arbiter_if.slave (requester handshake, ddr pair/enable, busy, grant)
//   Optional macro O_DDR_TX_PARITY_EN appends a {marker, even parity} beat to each frame.
module o_ddr_tx_arbiter #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1
) (
    input logic                clk_i,
    input logic                reset_n,
    input logic                enable_i,
    o_ddr_tx_arbiter_if.slave  bus
);
    localparam int BEATS = DATA_W / 2;
    localparam int CW    = ($clog2(BEATS) > 4) ? $clog2(BEATS) : 4;
`ifdef O_DDR_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2, PARITY = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;
`endif
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [1:0]        data_q, data_d;
    logic              en_q, en_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic              slot_free, last_beat, g, xfer;
    logic [1:0]        ready;
    logic [DATA_W-1:0] word;
`ifdef O_DDR_TX_PARITY_EN
    logic              par_q, par_d;
    assign last_beat = state_q == PARITY;
`else
    assign last_beat = state_q == SHIFT && cnt_q == '0;
`endif
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            data_q  <= 2'b00;
            en_q    <= 1'b0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
`ifdef O_DDR_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            en_q    <= en_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef O_DDR_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
    // Accept logic; a new word can chain straight onto the last beat only when no gap is owed.
    always_comb begin
        slot_free = reset_n && enable_i && (state_q == IDLE || (last_beat && GAP_CYCLES == 0));
        g         = bus.req_valid_i[1] && (!bus.req_valid_i[0] || !last_q);
        ready     = slot_free ? (bus.req_valid_i & (g ? 2'b10 : 2'b01)) : 2'b00;
        xfer      = |ready;
        word      = g ? bus.req_data1_i : bus.req_data0_i;
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        data_d  = data_q;
        en_d    = 1'b0;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef O_DDR_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (enable_i) begin
            if (xfer) begin
                state_d = SHIFT;
                cnt_d   = CW'(BEATS - 1);
                sr_d    = word >> 2;
                data_d  = word[1:0];
                en_d    = 1'b1;
                grant_d = g;
                last_d  = g;
`ifdef O_DDR_TX_PARITY_EN
                par_d   = ^word;
`endif
            end else if (state_q == SHIFT && cnt_q != '0) begin
                cnt_d  = cnt_q - 1'b1;
                sr_d   = sr_q >> 2;
                data_d = sr_q[1:0];
                en_d   = 1'b1;
`ifdef O_DDR_TX_PARITY_EN
            end else if (state_q == SHIFT) begin
                state_d = PARITY;
                data_d  = {1'b1, par_q};
                en_d    = 1'b1;
`endif
            end else if (last_beat && GAP_CYCLES > 0) begin
                state_d = GAP;
                cnt_d   = CW'(GAP_CYCLES - 1);
                data_d  = 2'b00;
            end else if (last_beat || (state_q == GAP && cnt_q == '0)) begin
                state_d = IDLE;
                data_d  = 2'b00;
            end else if (state_q == GAP) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end
    always_comb begin
        bus.req_ready_o = ready;
        bus.ddr_data_o  = data_q;
        bus.ddr_en_o    = en_q;
        bus.busy_o      = state_q != IDLE;
        bus.grant_id_o  = grant_q;
    end
endmodule

// File: tb/tb_o_ddr_tx_arbiter.sv
// tb_o_ddr_tx_arbiter: directed self-checking bench for o_ddr_tx_arbiter (GAP 1 and GAP 0 instances)
module tb_o_ddr_tx_arbiter;
`ifdef O_DDR_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_a = 1'b1;
    logic en_b = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    o_ddr_tx_arbiter_if #(.DATA_W(8)) if_a ();
    o_ddr_tx_arbiter_if #(.DATA_W(8)) if_b ();
    o_ddr_tx_arbiter #(.DATA_W(8), .GAP_CYCLES(1)) dut_a (
        .clk_i(clk), .reset_n(rst_n), .enable_i(en_a), .bus(if_a.slave));
    o_ddr_tx_arbiter #(.DATA_W(8), .GAP_CYCLES(0)) dut_b (
        .clk_i(clk), .reset_n(rst_n), .enable_i(en_b), .bus(if_b.slave));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_a.req_valid_i = 2'b01;
        if_a.req_data0_i = 8'h00;
        if_a.req_data1_i = 8'h00;
        if_b.req_valid_i = 2'b00;
        if_b.req_data0_i = 8'h00;
        if_b.req_data1_i = 8'h00;
        tick();
        n_cmp++; if (if_a.req_ready_o !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b want 00", if_a.req_ready_o); end
        n_cmp++; if (if_a.ddr_data_o !== 2'b00) begin n_bad++; $display("FAIL reset_data got %b want 00", if_a.ddr_data_o); end
        n_cmp++; if (if_a.ddr_en_o !== 1'b0) begin n_bad++; $display("FAIL reset_en got %b want 0", if_a.ddr_en_o); end
        n_cmp++; if (if_a.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", if_a.busy_o); end
        n_cmp++; if (if_a.grant_id_o !== 1'b0) begin n_bad++; $display("FAIL reset_grant got %b want 0", if_a.grant_id_o); end
        if_a.req_valid_i = 2'b00;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [1:0] exp [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        if_a.req_data0_i = 8'hB4;
        if_a.req_valid_i = 2'b01;
        #1;
        n_cmp++; if (if_a.req_ready_o !== 2'b01) begin n_bad++; $display("FAIL single_ready got %b want 01", if_a.req_ready_o); end
        tick();
        if_a.req_valid_i = 2'b00;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (if_a.ddr_data_o !== exp[i] || if_a.ddr_en_o !== 1'b1)
                begin n_bad++; $display("FAIL single_beat%0d got %b/%b want %b/1", i, if_a.ddr_data_o, if_a.ddr_en_o, exp[i]); end
            tick();
        end
        if (PB == 1) tick();
        n_cmp++; if (if_a.ddr_en_o !== 1'b0 || if_a.ddr_data_o !== 2'b00 || if_a.busy_o !== 1'b1)
            begin n_bad++; $display("FAIL single_gap got en %b data %b busy %b want 0/00/1", if_a.ddr_en_o, if_a.ddr_data_o, if_a.busy_o); end
        tick();
        n_cmp++; if (if_a.busy_o !== 1'b0) begin n_bad++; $display("FAIL single_idle busy got %b want 0", if_a.busy_o); end
    endtask

    task automatic test_round_robin();
        logic       eg [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] ep [2] = '{2'b01, 2'b10};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        if_a.req_data0_i = 8'h11;
        if_a.req_data1_i = 8'h22;
        if_a.req_valid_i = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 20 && !(|if_a.req_ready_o); i++) tick();
            n_cmp++; if (if_a.req_ready_o !== (eg[k] ? 2'b10 : 2'b01))
                begin n_bad++; $display("FAIL rr_ready%0d got %b want %b", k, if_a.req_ready_o, eg[k] ? 2'b10 : 2'b01); end
            tick();
            n_cmp++; if (if_a.grant_id_o !== eg[k] || if_a.ddr_data_o !== ep[eg[k]])
                begin n_bad++; $display("FAIL rr_grant%0d got id %b pair %b want %b/%b", k, if_a.grant_id_o, if_a.ddr_data_o, eg[k], ep[eg[k]]); end
        end
        if_a.req_valid_i = 2'b00;
        repeat (10) tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] q [$];
        q = {2'b11, 2'b11, 2'b11, 2'b11};
        if (PB == 1) q.push_back(2'b10);
        repeat (4) q.push_back(2'b00);
        if (PB == 1) q.push_back(2'b10);
        if_b.req_data0_i = 8'hFF;
        if_b.req_valid_i = 2'b01;
        #1;
        n_cmp++; if (if_b.req_ready_o !== 2'b01) begin n_bad++; $display("FAIL b2b_first_ready got %b want 01", if_b.req_ready_o); end
        tick();
        if_b.req_data0_i = 8'h00;
        #1;
        for (int i = 0; i < q.size(); i++) begin
            n_cmp++; if (if_b.ddr_data_o !== q[i] || if_b.ddr_en_o !== 1'b1 || if_b.req_ready_o !== (i == 3 + PB ? 2'b01 : 2'b00))
                begin n_bad++; $display("FAIL b2b_beat%0d got %b/%b rdy %b want %b/1", i, if_b.ddr_data_o, if_b.ddr_en_o, if_b.req_ready_o, q[i]); end
            tick();
            if (i == 3 + PB) if_b.req_valid_i = 2'b00;
            #1;
        end
        n_cmp++; if (if_b.ddr_en_o !== 1'b0 || if_b.busy_o !== 1'b0)
            begin n_bad++; $display("FAIL b2b_end got en %b busy %b want 0/0", if_b.ddr_en_o, if_b.busy_o); end
    endtask

    task automatic test_stall();
        if_a.req_data0_i = 8'hB4;
        if_a.req_valid_i = 2'b01;
        tick();
        if_a.req_valid_i = 2'b00;
        tick();
        n_cmp++; if (if_a.ddr_data_o !== 2'b01 || if_a.ddr_en_o !== 1'b1)
            begin n_bad++; $display("FAIL stall_pre got %b/%b want 01/1", if_a.ddr_data_o, if_a.ddr_en_o); end
        en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (if_a.ddr_data_o !== 2'b01 || if_a.ddr_en_o !== 1'b0 || if_a.busy_o !== 1'b1)
                begin n_bad++; $display("FAIL stall_hold%0d got %b/%b busy %b want 01/0/1", i, if_a.ddr_data_o, if_a.ddr_en_o, if_a.busy_o); end
        end
        en_a = 1'b1;
        tick();
        n_cmp++; if (if_a.ddr_data_o !== 2'b11 || if_a.ddr_en_o !== 1'b1)
            begin n_bad++; $display("FAIL stall_resume0 got %b/%b want 11/1", if_a.ddr_data_o, if_a.ddr_en_o); end
        tick();
        n_cmp++; if (if_a.ddr_data_o !== 2'b10 || if_a.ddr_en_o !== 1'b1)
            begin n_bad++; $display("FAIL stall_resume1 got %b/%b want 10/1", if_a.ddr_data_o, if_a.ddr_en_o); end
        repeat (6) tick();
        en_a = 1'b0;
        if_a.req_valid_i = 2'b01;
        #1;
        n_cmp++; if (if_a.req_ready_o !== 2'b00) begin n_bad++; $display("FAIL stall_ready got %b want 00", if_a.req_ready_o); end
        if_a.req_valid_i = 2'b00;
        en_a = 1'b1;
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        if_a.req_data0_i = 8'hB4;
        if_a.req_valid_i = 2'b01;
        tick();
        if_a.req_valid_i = 2'b00;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (if_a.ddr_data_o !== 2'b00 || if_a.ddr_en_o !== 1'b0 || if_a.busy_o !== 1'b0)
            begin n_bad++; $display("FAIL rstmid_async got %b/%b busy %b want 00/0/0", if_a.ddr_data_o, if_a.ddr_en_o, if_a.busy_o); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (if_a.ddr_en_o !== 1'b0) beats++;
        end
        n_cmp++; if (beats !== 0 || if_a.busy_o !== 1'b0)
            begin n_bad++; $display("FAIL rstmid_after got %0d beats busy %b want 0/0", beats, if_a.busy_o); end
    endtask

    task automatic test_parity();
        logic [1:0] exp [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        if_a.req_data0_i = 8'hB4;
        if_a.req_valid_i = 2'b01;
        tick();
        if_a.req_valid_i = 2'b00;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (if_a.ddr_data_o !== exp[i] || if_a.ddr_en_o !== 1'b1)
                begin n_bad++; $display("FAIL par_beat%0d got %b/%b want %b/1", i, if_a.ddr_data_o, if_a.ddr_en_o, exp[i]); end
            tick();
        end
        n_cmp++; if (if_a.ddr_data_o !== (PB == 1 ? 2'b10 : 2'b00) || if_a.ddr_en_o !== (PB == 1))
            begin n_bad++; $display("FAIL par_fifth got %b/%b want %b/%0d", if_a.ddr_data_o, if_a.ddr_en_o, PB == 1 ? 2'b10 : 2'b00, PB); end
        tick();
        n_cmp++; if (if_a.ddr_en_o !== 1'b0)
            begin n_bad++; $display("FAIL par_gap got en %b want 0", if_a.ddr_en_o); end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/o_ddr_tx_arbiter.md
Name: o_ddr_tx_arbiter

Overview:
- Controller that shares one O_DDR output lane between two requesters.
- Round-robin arbitration between two valid/ready word channels.
- The granted DATA_W-bit word is serialized into 2-bit SDR pairs, one per clk_i posedge, which feed the O_DDR D[1:0] input.
- Sits between fabric requesters and the O_DDR/O_BUF output path. Generates the O_DDR enable and inserts inter-frame gaps.

Parameters:
- DATA_W, 8, word width in bits; must be even and >= 2.
- GAP_CYCLES, 1, idle beats forced between frames; legal range 0..15.

Ports:
- clk_i  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- enable_i  input  1  global run enable; low freezes the block.
- req_valid_i  input  2  per-requester word valid.
- req_data0_i  input  DATA_W  requester 0 word.
- req_data1_i  input  DATA_W  requester 1 word.
- req_ready_o  output  2  per-requester accept strobe (combinational).
- ddr_data_o  output  2  registered pair to O_DDR D[1:0].
- ddr_en_o  output  1  registered O_DDR enable; high only on valid beats.
- busy_o  output  1  high when state != IDLE.
- grant_id_o  output  1  requester owning the current or last frame.

Behaviour:
- Reset values (reset_n low, asynchronous):
  - state = IDLE, ddr_data_o = 2'b00, ddr_en_o = 0, busy_o = 0.
  - grant_id_o = 0, last_served = 1 (requester 0 wins first).
  - req_ready_o = 2'b00.
- States and transitions:
  - IDLE: waits for a request.
  - SHIFT: beat counter runs DATA_W/2-1 down to 0.
  - GAP: gap counter runs GAP_CYCLES-1 down to 0.
  - Optional PARITY state; see Optional Feature.
- Accept window (slot_free) is asserted when enable_i = 1 and either:
  - state = IDLE, or
  - state = SHIFT on its last beat, GAP_CYCLES = 0, and no parity beat is pending.
- Arbitration:
  - When slot_free is asserted, the grant goes to the single valid requester.
  - If both requesters are valid, the grant goes to the one that is not last_served.
  - req_ready_o[g] = slot_free & req_valid_i[g]. At most one ready bit is high.
- Handshake:
  - A word transfers when valid & ready are both high.
  - On transfer: the shift register loads the word, grant_id_o and last_served are set to g, and state goes to SHIFT.
  - Requesters must hold valid and data stable until ready.
- Latency:
  - Transfer at cycle N puts bits[1:0] on ddr_data_o with ddr_en_o = 1 at N+1.
  - Each following cycle shifts right by 2, so pairs go out LSB first.
  - The last pair, bits[DATA_W-1:DATA_W-2], appears at N+DATA_W/2.
- End of SHIFT:
  - After the last beat, go to GAP if GAP_CYCLES > 0.
  - Otherwise go to SHIFT again if a new word transferred, else IDLE.
  - With GAP_CYCLES = 0 and continuous valids, ddr_en_o stays high with no bubble.
- GAP: ddr_en_o = 0, ddr_data_o = 2'b00. Returns to IDLE when the gap counter reaches 0.
- IDLE: ddr_en_o = 0 and ddr_data_o = 2'b00.
- enable_i low (any state):
  - State, counters, shift register and ddr_data_o hold.
  - ddr_en_o = 0 and req_ready_o = 0.
  - Shifting resumes with the next pair on the first cycle enable_i is high again; no beat is lost or repeated.
- Reset asserted mid-frame: the frame is aborted immediately, outputs take their reset values, and the word is not retransmitted.
- A requester that deasserts valid before ready is simply not granted; no state is held for it.

Optional Feature:
- Macro: O_DDR_TX_PARITY_EN.
- Defined:
  - After the last data beat, state goes to PARITY for one beat.
  - That beat drives ddr_data_o = {1'b1, ^word} with ddr_en_o = 1. Bit1 is the frame marker; bit0 is even parity.
  - It then proceeds to GAP or IDLE exactly as in the end-of-SHIFT rule.
  - The accept window moves to the PARITY beat when GAP_CYCLES = 0.
  - enable_i low also freezes this state.
- Undefined: no PARITY state exists and frames are exactly DATA_W/2 beats.

Test Plan:
- Single word: DATA_W = 8, GAP_CYCLES = 1, req0 sends 8'hB4.
  - Response: ready0 pulses at cycle N.
  - ddr_data_o = 00, 01, 11, 10 on N+1..N+4 with ddr_en_o = 1.
  - N+5: ddr_en_o = 0 (gap), then IDLE; busy_o falls at N+6.
- Round robin: both valid continuously, req0 = 8'h11, req1 = 8'h22.
  - Response: grants alternate 0, 1, 0, 1; grant_id_o follows.
  - Neither requester is granted twice in a row.
- Back-to-back: GAP_CYCLES = 0, req0 streams 8'hFF, 8'h00.
  - Response: 8 consecutive ddr_en_o = 1 beats, pairs 11 x4 then 00 x4, with no bubble.
- Stall: 8'hB4 in flight, enable_i low for 3 cycles after the second beat.
  - Response: ddr_en_o = 0 and ddr_data_o held at 01 during the stall.
  - Then 11, 10 follow; the frame completes intact.
- Reset mid-frame: reset_n low after the second beat of 8'hB4.
  - Response: outputs go to 0 immediately.
  - After release with no valids: IDLE, and no further ddr_en_o beats.
- O_DDR_TX_PARITY_EN defined, 8'hB4:
  - Response: 00, 01, 11, 10, then a 5th beat of 10 (marker = 1, parity = 0).
  - Then the gap.
